divmod_unit: RTL and testbench
==============================

DIVMOD_UNIT -- requirements
Module: divmod_unit

Interface
REQ-001 SHALL have parameter N_WIDTH, default 32, dividend and quotient width.
REQ-002 SHALL have parameter D_WIDTH, default 16, divisor and remainder width; legal range 1 <= D_WIDTH <= N_WIDTH.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, operands valid.
REQ-007 SHALL have port in_ready, output, 1, unit can accept operands.
REQ-008 SHALL have port dividend, input, N_WIDTH, unsigned numerator.
REQ-009 SHALL have port divisor, input, D_WIDTH, unsigned denominator.
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-012 SHALL have port quotient, output, N_WIDTH, floor(dividend/divisor).
REQ-013 SHALL have port remainder, output, D_WIDTH, dividend mod divisor.
REQ-014 SHALL have port div_by_zero, output, 1, set with result when divisor was 0.

Function
REQ-015 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE; accept = in_valid && in_ready at a rising edge.
REQ-017 SHALL latch dividend and divisor on accept; later input changes have no effect on the result.
REQ-018 SHALL go IDLE->BUSY on accept with divisor!=0, clearing the partial remainder (D_WIDTH+1 bits) and loading the dividend into the shift register.
REQ-019 SHALL perform one radix-2 restoring step per cycle in BUSY: shift remainder left taking the dividend MSB, subtract divisor, keep the difference and set the quotient bit if non-negative, else restore and clear the bit.
REQ-020 SHALL count exactly N_WIDTH steps, then go BUSY->DONE; out_valid rises N_WIDTH cycles after the accept edge.
REQ-021 SHALL go IDLE->DONE on accept with divisor==0, out_valid one cycle after accept, quotient all ones, remainder = dividend[D_WIDTH-1:0], div_by_zero=1.
REQ-022 SHALL clear div_by_zero for every nonzero-divisor result.
REQ-023 SHALL hold quotient, remainder, div_by_zero and out_valid stable in DONE while out_ready=0.
REQ-024 SHALL go DONE->IDLE on out_valid && out_ready; out_valid drops and in_ready rises in the next cycle, so no accept occurs in the handoff cycle.
REQ-025 SHALL ignore in_valid outside IDLE, because in_ready=0 there.
REQ-026 SHALL yield quotient*divisor + remainder == dividend with remainder < divisor for every nonzero divisor, including dividend < divisor and dividend=0.

Reset
REQ-027 SHALL, on rst_n low at any time including mid-BUSY or DONE, immediately force IDLE, in_ready=1 after release, out_valid=0, quotient=0, remainder=0, div_by_zero=0, step counter=0.
REQ-028 SHALL discard any in-flight operation on reset, with no result emitted after release.

Structure
REQ-029 SHALL take state encodings (IDLE=0, BUSY=1, DONE=2) and default widths from shared package divmod_pkg.
REQ-030 SHALL place one restoring iteration in combinational sub-module divmod_step (in: remainder, next bit, divisor; out: new remainder, quotient bit), instantiated once.
REQ-031 SHALL size the step counter as $clog2(N_WIDTH+1) bits.

Verification
REQ-032 SHALL check 100/7 -> quotient=14, remainder=2, div_by_zero=0, out_valid exactly 32 cycles after accept.
REQ-033 SHALL check 0xFFFFFFFF/0xFFFF -> quotient=0x00010001, remainder=0; and 5/9 -> quotient=0, remainder=5.
REQ-034 SHALL check 0x12345678/0 -> quotient=0xFFFFFFFF, remainder=0x5678, div_by_zero=1, out_valid 1 cycle after accept.
REQ-035 SHALL check backpressure: out_ready held 0 for 10 cycles in DONE -> outputs stable; in_valid pulses in BUSY/DONE ignored; in_ready returns the cycle after handshake.
REQ-036 SHALL check reset: rst_n pulsed low at BUSY step 10 -> IDLE, out_valid=0, all outputs 0; next 1000/10 -> quotient=100, remainder=0.
REQ-037 SHALL run 40 random ops, reconstructing the dividend with MAC_UNIT (quotient x divisor + remainder) and requiring an exact match.

Source files
------------

// File: rtl/divmod_pkg.sv
// Shared definitions for the unsigned divide/modulo unit.
//   N_WIDTH_DEF / D_WIDTH_DEF : default dividend/quotient and divisor/remainder widths
//   state_t                   : controller states (IDLE=0, BUSY=1, DONE=2)
//   cnt_width()               : step counter width able to hold 0..n
package divmod_pkg;

  localparam int unsigned N_WIDTH_DEF = 32;
  localparam int unsigned D_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/divmod_step.sv
// One radix-2 restoring division iteration (purely combinational).
//   rem_in  : current partial remainder (D_WIDTH+1 bits)
//   bit_in  : next dividend bit shifted into the remainder
//   divisor : unsigned divisor
//   rem_out : partial remainder after the trial subtraction / restore
//   q_bit   : quotient bit produced by this iteration
module divmod_step #(
  parameter int unsigned D_WIDTH = 16
) (
  input  logic [D_WIDTH:0]   rem_in,
  input  logic               bit_in,
  input  logic [D_WIDTH-1:0] divisor,
  output logic [D_WIDTH:0]   rem_out,
  output logic               q_bit
);

  localparam int unsigned RW = D_WIDTH + 1;
  localparam int unsigned SW = D_WIDTH + 2;
  localparam int unsigned TW = D_WIDTH + 3;

  logic [SW-1:0] shifted;
  logic [TW-1:0] trial;

  // Extra top bit of trial acts as the borrow/sign of the subtraction.
  assign shifted = {rem_in, bit_in};
  assign trial   = TW'(shifted) - TW'(divisor);
  assign q_bit   = ~trial[TW-1];
  assign rem_out = q_bit ? RW'(trial) : RW'(shifted);

endmodule

// File: rtl/divmod_unit.sv
// Sequential unsigned divider: one restoring step per cycle, N_WIDTH steps.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (ready only in IDLE)
//   dividend, divisor     : unsigned operands, latched on accept
//   out_valid / out_ready : result handshake (result held while stalled)
//   quotient, remainder   : floor(dividend/divisor), dividend mod divisor
//   div_by_zero           : result came from a zero divisor
module divmod_unit
  import divmod_pkg::*;
#(
  parameter int unsigned N_WIDTH = N_WIDTH_DEF,
  parameter int unsigned D_WIDTH = D_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_WIDTH-1:0] dividend,
  input  logic [D_WIDTH-1:0] divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_WIDTH-1:0] quotient,
  output logic [D_WIDTH-1:0] remainder,
  output logic               div_by_zero
);

  localparam int unsigned CW = cnt_width(N_WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(N_WIDTH - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [D_WIDTH:0]   rem_q, rem_d;
  logic [N_WIDTH-1:0] shf_q, shf_d;
  logic [D_WIDTH-1:0] dvs_q, dvs_d;
  logic [N_WIDTH-1:0] quotient_d;
  logic [D_WIDTH-1:0] remainder_d;
  logic               div_by_zero_d;
  logic               out_valid_d;
  logic               in_ready_d;

  logic [D_WIDTH:0]   step_rem;
  logic               step_q;

  // Dividend shifts out of the top of shf_q while quotient bits shift in at the bottom.
  divmod_step #(
    .D_WIDTH (D_WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .bit_in  (shf_q[N_WIDTH-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      shf_q       <= '0;
      dvs_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      shf_q       <= shf_d;
      dvs_q       <= dvs_d;
      quotient    <= quotient_d;
      remainder   <= remainder_d;
      div_by_zero <= div_by_zero_d;
      out_valid   <= out_valid_d;
      in_ready    <= in_ready_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    shf_d         = shf_q;
    dvs_d         = dvs_q;
    quotient_d    = quotient;
    remainder_d   = remainder;
    div_by_zero_d = div_by_zero;
    out_valid_d   = out_valid;
    in_ready_d    = in_ready;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          dvs_d      = divisor;
          in_ready_d = 1'b0;
          if (divisor == '0) begin
            // Zero divisor skips the iteration entirely.
            quotient_d    = '1;
            remainder_d   = dividend[D_WIDTH-1:0];
            div_by_zero_d = 1'b1;
            out_valid_d   = 1'b1;
            state_d       = DONE;
          end else begin
            rem_d   = '0;
            shf_d   = dividend;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        rem_d = step_rem;
        shf_d = N_WIDTH'({shf_q, step_q});
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          quotient_d    = N_WIDTH'({shf_q, step_q});
          remainder_d   = step_rem[D_WIDTH-1:0];
          div_by_zero_d = 1'b0;
          out_valid_d   = 1'b1;
          state_d       = DONE;
        end
      end

      DONE: begin
        if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_divmod_unit.sv
// Scoreboard bench for divmod_unit: expected results are queued when operands
// are accepted and compared when the unit presents its result.
module tb_divmod_unit;

  localparam int unsigned NW = 32;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          div_by_zero;

  typedef struct {
    logic [NW-1:0] a;
    logic [DW-1:0] b;
    logic [NW-1:0] q;
    logic [DW-1:0] r;
    logic          dz;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  divmod_unit #(
    .N_WIDTH (NW),
    .D_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present operands until accepted, then scramble the inputs and queue the expectation.
  task automatic accept_op(input logic [NW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = DW'($urandom);
    e.a = a;
    e.b = b;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a[DW-1:0];
      e.dz = 1'b1;
    end else begin
      e.q  = a / NW'(b);
      e.r  = DW'(a % NW'(b));
      e.dz = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Wait for the result (counting edges since the accept edge), optionally stall
  // and inject ignored in_valid pulses, then handshake and score.
  task automatic collect(input int hold, input bit noise);
    exp_t          e;
    int            lat;
    int            exp_lat;
    logic [NW-1:0] q_s;
    logic [DW-1:0] r_s;
    logic          dz_s;
    logic [63:0]   mac;
    e = sb.pop_front();
    // Zero divisor: valid already in the cycle right after accept; otherwise NW edges later.
    exp_lat = (e.b == '0) ? 0 : int'(NW);
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        dividend = $urandom;
        divisor  = DW'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    q_s  = quotient;
    r_s  = remainder;
    dz_s = div_by_zero;
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        dividend = $urandom;
        divisor  = DW'($urandom);
      end
      @(negedge clk);
      chk("hold_stable", {13'd0, out_valid, dz_s, quotient, remainder},
          {13'd0, 1'b1, div_by_zero, q_s, r_s});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("ready_low_in_done", 64'(in_ready), 64'd0);
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", 64'(out_valid), 64'd0);
    chk("ready_return", 64'(in_ready), 64'd1);
    chk("quotient", 64'(q_s), 64'(e.q));
    chk("remainder", 64'(r_s), 64'(e.r));
    chk("div_by_zero", 64'(dz_s), 64'(e.dz));
    if (e.b != '0) begin
      mac = 64'(q_s) * 64'(e.b) + 64'(r_s);
      chk("mac_rebuild", mac, 64'(e.a));
      chk("rem_lt_div", 64'(r_s < e.b), 64'd1);
    end
  endtask

  task automatic run_op(input logic [NW-1:0] a, input logic [DW-1:0] b,
                        input int hold, input bit noise);
    accept_op(a, b);
    collect(hold, noise);
  endtask

  initial begin
    int ghost;
    logic [NW-1:0] ra;
    logic [DW-1:0] rb;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);

    run_op(32'd100, 16'd7, 0, 1'b0);
    run_op(32'hFFFF_FFFF, 16'hFFFF, 0, 1'b0);
    run_op(32'd5, 16'd9, 0, 1'b0);
    run_op(32'h1234_5678, 16'd0, 0, 1'b0);
    run_op(32'd1234567, 16'd89, 10, 1'b1);
    run_op(32'd0, 16'd7, 0, 1'b0);
    run_op(32'hDEAD_BEEF, 16'd0, 3, 1'b1);
    run_op(32'hFFFF_FFFF, 16'd1, 0, 1'b0);

    // Reset in the middle of BUSY: everything clears and nothing is emitted afterwards.
    accept_op(32'h00AB_CDEF, 16'd3);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_quotient", 64'(quotient), 64'd0);
    chk("midrst_remainder", 64'(remainder), 64'd0);
    chk("midrst_dbz", 64'(div_by_zero), 64'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    ghost = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) ghost++;
    end
    chk("no_ghost_result", 64'(ghost), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    run_op(32'd1000, 16'd10, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rb = DW'($urandom_range(1, 65535));
      if (i % 5 == 0) ra = NW'($urandom_range(0, int'(rb)));
      else            ra = $urandom;
      run_op(ra, rb, i % 3, 1'(i % 2));
    end

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
